// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc_unit
//  Purpose  : Coprocessor-0 exception/interrupt unit. Receives the victim PC,
//             branch-delay flag and exception code carried down the pipeline,
//             plus level-sensitive hardware interrupt lines. Raises Req
//             (flush + redirect to handler) and holds SR, Cause, EPC and PRId.
//  Ports    : clk        - system clock
//             reset      - asynchronous, active-low reset
//             en         - mtc0 write enable (M-stage)
//             CP0Add     - CP0 register number for mfc0/mtc0
//             CP0In      - mtc0 write data
//             CP0Out     - mfc0 read data (combinational)
//             VPC        - PC of the M-stage instruction
//             BDIn       - victim instruction sits in a branch delay slot
//             ExcCodeIn  - pipelined exception code, 0 = none
//             HWInt      - external interrupt lines (level-sensitive)
//             EXLClr     - eret in M-stage
//             EPCOut     - current EPC, eret target
//             Req        - exception/interrupt request (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
   parameter logic [31:0] PRID_VAL = 32'h2023_0007,
   parameter int unsigned IM_WIDTH = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [4:0]          CP0Add,
   input  logic [31:0]         CP0In,
   output logic [31:0]         CP0Out,
   input  logic [31:0]         VPC,
   input  logic                BDIn,
   input  logic [4:0]          ExcCodeIn,
   input  logic [IM_WIDTH-1:0] HWInt,
   input  logic                EXLClr,
   output logic [31:0]         EPCOut,
   output logic                Req
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;
   // IM in SR and IP in Cause share the same bit position.
   localparam int unsigned IM_LSB    = 10;

   // ---------------------------------------------------------------- state
   logic [IM_WIDTH-1:0] im_q, im_d;
   logic                exl_q, exl_d;
   logic                ie_q, ie_d;
   logic                bd_q, bd_d;
   logic [IM_WIDTH-1:0] ip_q, ip_d;
   logic [4:0]          exc_code_q, exc_code_d;
   // EPC is always word aligned, so only the upper 30 bits are stored.
   logic [29:0]         epc_q, epc_d;

   logic                int_req;
   logic                exc_req;
   logic [29:0]         victim_word;
   logic [31:0]         sr_val;
   logic [31:0]         cause_val;

   // ------------------------------------------------------- request logic
   always_comb begin
      int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
      exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
      Req     = int_req | exc_req;
   end

   // Word address of the restart point: a delay-slot victim restarts at the
   // branch one word earlier. Subtracting one word from VPC[31:2] equals
   // (VPC-4)[31:2] with the same 32-bit wrap-around.
   always_comb begin
      victim_word = BDIn ? (VPC[31:2] - 30'd1) : VPC[31:2];
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      // Pending lines are sampled every cycle, independent of masking.
      ip_d       = HWInt;

      if (Req) begin
         // The M-stage instruction is flushed, so any mtc0 it carries is dropped.
         exl_d      = 1'b1;
         bd_d       = BDIn;
         exc_code_d = int_req ? 5'd0 : ExcCodeIn;
         epc_d      = victim_word;
      end else begin
         if (en && (CP0Add == ADDR_SR)) begin
            im_d  = CP0In[IM_LSB +: IM_WIDTH];
            exl_d = CP0In[1];
            ie_d  = CP0In[0];
         end
         if (en && (CP0Add == ADDR_EPC)) begin
            epc_d = CP0In[31:2];
         end
         // eret overrides a simultaneous mtc0 to SR for the EXL bit only.
         if (EXLClr) begin
            exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= 5'd0;
         epc_q      <= 30'd0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   // ------------------------------------------------------------- readout
   always_comb begin
      sr_val                      = 32'd0;
      sr_val[IM_LSB +: IM_WIDTH]  = im_q;
      sr_val[1]                   = exl_q;
      sr_val[0]                   = ie_q;

      cause_val                   = 32'd0;
      cause_val[31]               = bd_q;
      cause_val[IM_LSB +: IM_WIDTH] = ip_q;
      cause_val[6:2]              = exc_code_q;
   end

   // Reads show registered state only; a same-cycle mtc0 is not bypassed.
   always_comb begin
      case (CP0Add)
         ADDR_SR:    CP0Out = sr_val;
         ADDR_CAUSE: CP0Out = cause_val;
         ADDR_EPC:   CP0Out = {epc_q, 2'b00};
         ADDR_PRID:  CP0Out = PRID_VAL;
         default:    CP0Out = 32'd0;
      endcase
   end

   always_comb begin
      EPCOut = {epc_q, 2'b00};
   end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_exc_unit
//  Purpose  : Self-checking bench for cp0_exc_unit. Stimulus pushes expected
//             {Req, CP0Out, EPCOut} computed by a word-level reference model
//             into a queue; an independent monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_cp0_exc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  CP0Add;
   logic [31:0] CP0In;
   logic [31:0] CP0Out;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] EPCOut;
   logic        Req;

   int checks   = 0;
   int failures = 0;

   cp0_exc_unit #(
      .PRID_VAL (32'h2023_0007),
      .IM_WIDTH (6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .CP0Add    (CP0Add),
      .CP0In     (CP0In),
      .CP0Out    (CP0Out),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .EPCOut    (EPCOut),
      .Req       (Req)
   );

   always #10 clk = ~clk;

   // ------------------------------------------------------ reference model
   // Architectural registers kept as whole 32-bit words.
   logic [31:0] m_sr, m_cause, m_epc;

   typedef struct {
      string       name;
      logic        req;
      logic [31:0] dout;
      logic [31:0] epc;
   } exp_t;

   exp_t exp_q[$];
   event exp_ev;

   task automatic model_reset();
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
   endtask

   function automatic logic m_int_req();
      return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return m_int_req() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h2023_0007;
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model across one rising edge using the inputs now driven.
   task automatic model_step();
      logic [31:0] ns, nc, ne;
      if (!reset) begin
         model_reset();
         return;
      end
      ns = m_sr;
      nc = m_cause;
      ne = m_epc;
      if (m_req()) begin
         ns = m_sr | 32'h2;
         nc = {BDIn, 15'd0, HWInt, 3'd0, (m_int_req() ? 5'd0 : ExcCodeIn), 2'd0};
         ne = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;
      end else begin
         if (en && CP0Add == 5'd12) ns = CP0In & 32'h0000_FC03;
         if (en && CP0Add == 5'd14) ne = CP0In & 32'hFFFF_FFFC;
         if (EXLClr) ns = ns & ~32'h2;
         nc = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      end
      m_sr    = ns;
      m_cause = nc;
      m_epc   = ne;
   endtask

   task automatic push_exp(input string name);
      exp_t e;
      e.name = name;
      e.req  = m_req();
      e.dout = m_read(CP0Add);
      e.epc  = m_epc;
      exp_q.push_back(e);
      -> exp_ev;
   endtask

   task automatic set_in(input logic t_en, input logic [4:0] t_add,
                         input logic [31:0] t_din, input logic [31:0] t_vpc,
                         input logic t_bd, input logic [4:0] t_exc,
                         input logic [5:0] t_hw, input logic t_clr);
      en        = t_en;
      CP0Add    = t_add;
      CP0In     = t_din;
      VPC       = t_vpc;
      BDIn      = t_bd;
      ExcCodeIn = t_exc;
      HWInt     = t_hw;
      EXLClr    = t_clr;
   endtask

   // One clock cycle: drive at the falling edge, check mid-low-phase,
   // advance the model, and return at the next falling edge.
   task automatic cyc(input logic t_en, input logic [4:0] t_add,
                      input logic [31:0] t_din, input logic [31:0] t_vpc,
                      input logic t_bd, input logic [4:0] t_exc,
                      input logic [5:0] t_hw, input logic t_clr,
                      input string name);
      set_in(t_en, t_add, t_din, t_vpc, t_bd, t_exc, t_hw, t_clr);
      #2;
      push_exp(name);
      model_step();
      @(negedge clk);
   endtask

   // ------------------------------------------------------------- monitor
   initial begin
      exp_t e;
      forever begin
         @(exp_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (Req !== e.req || CP0Out !== e.dout || EPCOut !== e.epc) begin
               failures++;
               $display("FAIL %s: got Req=%0b CP0Out=%h EPCOut=%h, expected Req=%0b CP0Out=%h EPCOut=%h",
                        e.name, Req, CP0Out, EPCOut, e.req, e.dout, e.epc);
            end
         end
      end
   end

   // ------------------------------------------------------------ watchdog
   initial begin
      #5_000_000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      reset = 1'b0;
      set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
      model_reset();
      @(negedge clk);

      // Reset state, read while held in reset and after release.
      cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, "rst_sr");
      cyc(0, 5'd15, 0, 0, 0, 0, 0, 0, "rst_prid");
      reset = 1'b1;
      cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, "rd_sr");
      cyc(0, 5'd13, 0, 0, 0, 0, 0, 0, "rd_cause");
      cyc(0, 5'd14, 0, 0, 0, 0, 0, 0, "rd_epc");
      cyc(0, 5'd15, 0, 0, 0, 0, 0, 0, "rd_prid");
      cyc(0, 5'd3,  0, 0, 0, 0, 0, 0, "rd_other");

      // Write masking; Cause is read-only to mtc0.
      cyc(1, 5'd12, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "wr_sr_all");
      cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, "rd_sr_masked");
      cyc(1, 5'd13, 32'h1234, 0, 0, 0, 0, 0, "wr_cause");
      cyc(0, 5'd13, 0, 0, 0, 0, 0, 0, "rd_cause_unchanged");

      // Interrupt, non-delay-slot.
      cyc(1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0, "wr_sr_401");
      cyc(0, 5'd13, 0, 32'h3010, 0, 0, 6'b000001, 0, "int_req");
      cyc(0, 5'd14, 0, 32'h3010, 0, 0, 6'b000001, 0, "int_epc_held");
      cyc(0, 5'd13, 0, 32'h3010, 0, 0, 6'b000001, 0, "int_cause");
      cyc(0, 5'd12, 0, 32'h3010, 0, 0, 6'b000001, 0, "int_sr");

      // eret together with mtc0 SR=0, then delay-slot exception dropping mtc0.
      cyc(1, 5'd12, 32'd0, 0, 0, 0, 0, 1, "eret_wr_sr0");
      cyc(1, 5'd14, 32'hDEAD, 32'h3024, 1, 5'd4, 0, 0, "exc_req_bd");
      cyc(0, 5'd14, 0, 0, 0, 0, 0, 0, "exc_epc");
      cyc(0, 5'd13, 0, 0, 0, 0, 0, 0, "exc_cause");
      cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, "exc_sr");

      // EXL masks exceptions; eret reopens them.
      cyc(0, 5'd13, 0, 32'h5000, 0, 5'd10, 0, 0, "exl_mask");
      cyc(0, 5'd14, 0, 32'h5000, 0, 5'd10, 0, 0, "exl_mask_epc");
      cyc(0, 5'd12, 0, 32'h5000, 0, 5'd10, 0, 1, "eret");
      cyc(0, 5'd14, 0, 32'h0, 1, 5'd10, 0, 0, "reexc_wrap");
      cyc(0, 5'd14, 0, 0, 0, 0, 0, 0, "epc_wrap");
      cyc(0, 5'd13, 0, 0, 0, 0, 0, 0, "cause_wrap");

      // eret wins the EXL bit over a concurrent mtc0 SR.
      cyc(1, 5'd12, 32'h0000_FC03, 0, 0, 0, 0, 1, "eret_vs_mtc0");
      cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, "sr_after_eret_mtc0");

      // Async reset while EXL=1 with populated registers.
      cyc(0, 5'd12, 0, 32'h4000, 0, 0, 6'b000010, 0, "int2_req");
      set_in(0, 5'd12, 0, 0, 0, 0, 6'b000010, 0);
      #2 push_exp("pre_arst_sr");
      #2 reset = 1'b0;
      model_reset();
      #1 push_exp("arst_sr");
      CP0Add = 5'd13;
      #1 push_exp("arst_cause");
      CP0Add = 5'd14;
      #1 push_exp("arst_epc");
      @(negedge clk);
      reset = 1'b1;

      // Async reset while an interrupt request is active.
      cyc(1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0, "wr_sr_401b");
      set_in(0, 5'd12, 0, 32'h5000, 0, 0, 6'b000001, 0);
      #2 push_exp("intb_req");
      #2 reset = 1'b0;
      model_reset();
      #1 push_exp("intb_arst");
      @(negedge clk);
      reset = 1'b1;
      cyc(0, 5'd13, 0, 0, 0, 0, 0, 0, "post_arst_cause");

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [4:0]  r_add;
         logic [31:0] r_vpc;
         logic [5:0]  r_hw;
         int          sel;
         sel   = $urandom_range(0, 5);
         r_add = (sel < 4) ? 5'(12 + sel) : 5'($urandom_range(0, 31));
         r_vpc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         r_hw  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         cyc(1'($urandom_range(0, 1)), r_add, $urandom, r_vpc,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
             r_hw, ($urandom_range(0, 5) == 0), "rand");
      end

      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
